// File: rtl/iob_fp_add_arb_pkg.sv
// Shared sizing helpers for the floating-point adder arbiter.
package iob_fp_add_arb_pkg;

  // Requester id (tag) width; kept at least one bit wide.
  function automatic int tag_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Width of a per-requester in-flight counter able to hold 0..max_outst.
  function automatic int cnt_w(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/iob_fp_add_arb_rr.sv
// Round-robin grant: first eligible requester at or after ptr, wrapping.
module iob_fp_add_arb_rr #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_fp_add_arb.sv
// Arbitrates N_REQ requesters onto one external fixed-latency FP adder and
// routes each result back to its issuer using a tag delay line.
module iob_fp_add_arb
  import iob_fp_add_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 5,
  parameter int MAX_OUTST = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]   req_op_a_i,
  input  logic [N_REQ*DATA_W-1:0]   req_op_b_i,
  output logic [N_REQ-1:0]          resp_valid_o,
  output logic [DATA_W-1:0]         resp_res_o,
  output logic                      add_rst_o,
  output logic                      add_start_o,
  output logic [DATA_W-1:0]         add_op_a_o,
  output logic [DATA_W-1:0]         add_op_b_o,
  input  logic                      add_done_i,
  input  logic [DATA_W-1:0]         add_res_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int TAG_W = tag_w(N_REQ);
  localparam int CNT_W = cnt_w(MAX_OUTST);

  logic [TAG_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  outst_q [N_REQ];
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [TAG_W-1:0]  gnt_id;
  logic              xfer;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  start_id_q;
  logic [LATENCY-1:0] tag_vld_q;
  logic [TAG_W-1:0]  tag_id_q [LATENCY];
  logic              tag_out_vld;
  logic [TAG_W-1:0]  tag_out_id;
  logic              resp_fire;
  logic [N_REQ-1:0]  resp_onehot;
  logic              outst_any;

  // The adder shares our reset so both sides drop in-flight work together.
  assign add_rst_o = ~rst_n_i;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = en_i & req_valid_i[i] & (outst_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  iob_fp_add_arb_rr #(
    .N_REQ (N_REQ),
    .PTR_W (TAG_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant)
  );

  assign req_ready_o = grant;
  assign xfer        = |grant;

  always_comb begin
    gnt_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_id = TAG_W'(i);
        sel_a  = req_op_a_i[i*DATA_W +: DATA_W];
        sel_b  = req_op_b_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q       <= '0;
      add_start_o <= 1'b0;
      add_op_a_o  <= '0;
      add_op_b_o  <= '0;
      start_id_q  <= '0;
    end else begin
      add_start_o <= xfer;
      if (xfer) begin
        ptr_q      <= (gnt_id == TAG_W'(N_REQ - 1)) ? '0 : gnt_id + TAG_W'(1);
        add_op_a_o <= sel_a;
        add_op_b_o <= sel_b;
        start_id_q <= gnt_id;
      end
    end
  end

  // Stage 0 follows add_start_o by one cycle, so the last stage lines up
  // with add_done_i exactly LATENCY cycles after the adder start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= add_start_o;
      tag_id_q[0]  <= start_id_q;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign tag_out_vld = tag_vld_q[LATENCY-1];
  assign tag_out_id  = tag_id_q[LATENCY-1];
  assign resp_fire   = add_done_i & tag_out_vld;

  always_comb begin
    resp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_onehot[i] = (tag_out_id == TAG_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_valid_o <= '0;
      resp_res_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      resp_valid_o <= resp_fire ? resp_onehot : '0;
      if (resp_fire) resp_res_o <= add_res_i;
      if (add_done_i != tag_out_vld) err_o <= 1'b1;
    end
  end

  // A grant and a response for the same requester cancel out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_REQ; i++) outst_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && !resp_valid_o[i] && outst_q[i] < CNT_W'(MAX_OUTST)) begin
          outst_q[i] <= outst_q[i] + CNT_W'(1);
        end else if (!grant[i] && resp_valid_o[i] && outst_q[i] != '0) begin
          outst_q[i] <= outst_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    outst_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (outst_q[i] != '0) outst_any = 1'b1;
    end
  end

  assign busy_o = add_start_o | (|tag_vld_q) | (|resp_valid_o) | outst_any;

endmodule

// File: tb/tb_iob_fp_add_arb.sv
// Self-checking bench for iob_fp_add_arb: grant table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_iob_fp_add_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int L   = 5;
  localparam int MXO = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    v_valid;
  logic [DW-1:0]   v_a [N];
  logic [DW-1:0]   v_b [N];
  logic [N*DW-1:0] op_a_bus;
  logic [N*DW-1:0] op_b_bus;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_res;
  logic            add_rst;
  logic            add_start;
  logic [DW-1:0]   add_op_a;
  logic [DW-1:0]   add_op_b;
  logic            add_done;
  logic [DW-1:0]   add_res;
  logic            busy;
  logic            err;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign op_a_bus[g*DW +: DW] = v_a[g];
    assign op_b_bus[g*DW +: DW] = v_b[g];
  end

  iob_fp_add_arb #(.N_REQ(N), .DATA_W(DW), .LATENCY(L), .MAX_OUTST(MXO)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .req_valid_i  (v_valid),
    .req_ready_o  (req_ready),
    .req_op_a_i   (op_a_bus),
    .req_op_b_i   (op_b_bus),
    .resp_valid_o (resp_valid),
    .resp_res_o   (resp_res),
    .add_rst_o    (add_rst),
    .add_start_o  (add_start),
    .add_op_a_o   (add_op_a),
    .add_op_b_o   (add_op_b),
    .add_done_i   (add_done),
    .add_res_i    (add_res),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Single-precision add done in real arithmetic (normal numbers only).
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic int enc(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Bench-side adder: fixed latency, results keyed by cycle.
  logic        ad_done [64];
  logic [31:0] ad_res  [64];
  logic        inj;

  // Transaction-level model state.
  typedef struct {int due; int id; logic [31:0] res;} rsp_t;
  rsp_t        rq [$];
  int          m_ptr;
  int          m_outst [N];
  logic        m_st_v;
  logic [31:0] m_st_a, m_st_b, m_res;
  logic        m_err;

  // Observed DUT activity for the directed sequences.
  int dut_gl [$];
  int st_cyc [$];
  int rsp_cyc [$];
  int rsp_id [$];

  task automatic clear_obs();
    dut_gl.delete(); st_cyc.delete(); rsp_cyc.delete(); rsp_id.delete();
  endtask

  task automatic cycle();
    int g, idx, tot;
    logic [N-1:0] e_rdy, e_rv;
    logic tv;
    add_done = ad_done[cyc % 64] | inj;
    add_res  = ad_res[cyc % 64];
    ad_done[cyc % 64] = 1'b0;
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v_valid[idx] && m_outst[idx] < MXO) g = idx;
      end
    end
    e_rdy = (g >= 0) ? N'(1 << g) : '0;
    e_rv  = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv  = N'(1 << rq[0].id);
      m_res = rq[0].res;
    end
    tot = 0;
    for (int i = 0; i < N; i++) tot += m_outst[i];
    chk("ready", req_ready, e_rdy);
    chk("add_start", add_start, m_st_v);
    chk("add_op_a", add_op_a, m_st_a);
    chk("add_op_b", add_op_b, m_st_b);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_res", resp_res, m_res);
    chk("busy", busy, tot != 0);
    chk("err", err, m_err);
    if (req_ready != '0) dut_gl.push_back(enc(req_ready));
    if (add_start) st_cyc.push_back(cyc);
    if (resp_valid != '0) begin
      rsp_cyc.push_back(cyc);
      rsp_id.push_back(enc(resp_valid));
    end
    if (add_start) begin
      ad_done[(cyc + L) % 64] = 1'b1;
      ad_res[(cyc + L) % 64]  = fadd(add_op_a, add_op_b);
    end
    tv = 1'b0;
    foreach (rq[j]) if (rq[j].due == cyc + 1) tv = 1'b1;
    if (inj && !tv) m_err = 1'b1;
    if (e_rv != '0) begin
      m_outst[rq[0].id]--;
      void'(rq.pop_front());
    end
    m_st_v = (g >= 0);
    if (g >= 0) begin
      m_outst[g]++;
      m_ptr  = (g + 1) % N;
      m_st_a = v_a[g];
      m_st_b = v_b[g];
      rq.push_back('{cyc + 2 + L, g, fadd(v_a[g], v_b[g])});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_now);
    rst_n = 1'b0;
    inj = 1'b0;
    add_done = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_ready", req_ready, '0);
      chk("rst_add_start", add_start, 0);
      chk("rst_add_op_a", add_op_a, 0);
      chk("rst_add_op_b", add_op_b, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_res", resp_res, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_add_rst", add_rst, 1);
    end
    for (int i = 0; i < 64; i++) begin ad_done[i] = 1'b0; ad_res[i] = '0; end
    rq.delete();
    m_ptr = 0; m_st_v = 0; m_st_a = '0; m_st_b = '0; m_res = '0; m_err = 0;
    for (int i = 0; i < N; i++) m_outst[i] = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      v_a[i] = {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
      v_b[i] = {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
    end
  endtask

  typedef struct {logic en; logic [N-1:0] valid; logic [N-1:0] exp_rdy;} gvec_t;
  gvec_t gtab [8];

  initial begin
    gtab[0] = '{1'b1, 4'b0000, 4'b0000};
    gtab[1] = '{1'b1, 4'b0001, 4'b0001};
    gtab[2] = '{1'b1, 4'b1010, 4'b0010};
    gtab[3] = '{1'b1, 4'b1000, 4'b1000};
    gtab[4] = '{1'b0, 4'b1111, 4'b0000};
    gtab[5] = '{1'b1, 4'b1100, 4'b0100};
    gtab[6] = '{1'b1, 4'b1111, 4'b0001};
    gtab[7] = '{1'b1, 4'b0110, 4'b0010};

    rst_n = 1'b0; en = 1'b0; v_valid = '0; inj = 1'b0;
    add_done = 1'b0; add_res = '0;
    for (int i = 0; i < N; i++) begin v_a[i] = '0; v_b[i] = '0; end
    @(negedge clk);
    do_reset(1'b1);

    // Combinational grant from ptr=0, no clock edge between rows.
    rand_ops();
    foreach (gtab[r]) begin
      en = gtab[r].en;
      v_valid = gtab[r].valid;
      #1;
      chk($sformatf("grant_tab%0d", r), req_ready, gtab[r].exp_rdy);
    end
    v_valid = '0;
    en = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    // Single request from requester 2: 1.0 + 2.0.
    do_reset(1'b0);
    v_a[2] = 32'h3F80_0000;
    v_b[2] = 32'h4000_0000;
    v_valid = 4'b0100;
    cycle();
    v_valid = '0;
    #1;
    chk("single_start", add_start, 1);
    chk("single_op_a", add_op_a, 32'h3F80_0000);
    for (int c = 0; c < 6; c++) cycle();
    #1;
    chk("single_resp_valid", resp_valid, 4'b0100);
    chk("single_resp_res", resp_res, 32'h4040_0000);
    for (int c = 0; c < 3; c++) cycle();

    // All four valid for 8 cycles: strict rotation, in-order responses.
    do_reset(1'b0);
    rand_ops();
    v_valid = 4'b1111;
    for (int c = 0; c < 8; c++) cycle();
    v_valid = '0;
    for (int c = 0; c < 10; c++) cycle();
    chk("rr_grant_count", dut_gl.size(), 8);
    chk("rr_resp_count", rsp_id.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < dut_gl.size()) chk($sformatf("rr_order%0d", i), dut_gl[i], i % 4);
      if (i < rsp_id.size() && i < st_cyc.size()) begin
        chk($sformatf("rr_resp_id%0d", i), rsp_id[i], i % 4);
        chk($sformatf("rr_resp_gap%0d", i), rsp_cyc[i] - st_cyc[i], 6);
      end
    end

    // In-flight limit on requester 0.
    do_reset(1'b0);
    v_valid = 4'b0001;
    for (int c = 0; c < 8; c++) cycle();
    chk("limit_grants_8cyc", dut_gl.size(), MXO);
    cycle();
    chk("limit_regrant", dut_gl.size(), MXO + 1);
    v_valid = '0;
    for (int c = 0; c < 12; c++) cycle();

    // en_i dropped with 3 operations in flight.
    do_reset(1'b0);
    v_valid = 4'b0111;
    for (int c = 0; c < 3; c++) cycle();
    en = 1'b0;
    v_valid = 4'b1111;
    for (int c = 0; c < 12; c++) cycle();
    chk("en_grants", dut_gl.size(), 3);
    chk("en_resps", rsp_id.size(), 3);
    #1;
    chk("en_busy_end", busy, 0);
    en = 1'b1;
    v_valid = '0;

    // Reset with 5 in flight.
    do_reset(1'b0);
    v_valid = 4'b1111;
    for (int c = 0; c < 5; c++) cycle();
    v_valid = '0;
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) cycle();
    chk("rst_no_resp", rsp_id.size(), 0);
    #1;
    chk("rst_err_clear", err, 0);

    // Spurious done with an empty tag line.
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    #1;
    chk("spurious_err", err, 1);
    for (int c = 0; c < 5; c++) cycle();
    chk("spurious_no_resp", rsp_id.size(), 0);

    // Randomized traffic.
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      v_valid = N'($urandom);
      en = ($urandom_range(9, 0) != 0);
      cycle();
    end
    v_valid = '0;
    en = 1'b1;
    for (int c = 0; c < 12; c++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/iob_fp_add_arb.md
IOB_FP_ADD_ARB -- requirements
Module: iob_fp_add_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters, 2..16.
REQ-002 The block SHALL have parameter DATA_W, default 32: operand and result width.
REQ-003 The block SHALL have parameter LATENCY, default 5: fixed start-to-done latency of the shared adder, in cycles.
REQ-004 The block SHALL have parameter MAX_OUTST, default 4: per-requester in-flight limit, 1..15.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 (clock); rst_n_i input 1 (async active-low reset).
REQ-006 The block SHALL have these requester ports:
- en_i input 1: grant enable.
- req_valid_i input N_REQ: per-requester request.
- req_ready_o output N_REQ: per-requester grant, one-hot or zero.
- req_op_a_i input N_REQ*DATA_W: operand A, requester i at slice [i*DATA_W +: DATA_W].
- req_op_b_i input N_REQ*DATA_W: operand B, same slicing.
- resp_valid_o output N_REQ: one-cycle result strobe.
- resp_res_o output DATA_W: result, shared by all requesters.
REQ-007 The block SHALL have these adder-side ports:
- add_start_o output 1.
- add_op_a_o output DATA_W.
- add_op_b_o output DATA_W.
- add_done_i input 1.
- add_res_i input DATA_W.
REQ-008 The block SHALL have these status outputs:
- busy_o output 1: any operation in flight.
- err_o output 1: sticky sequencing error.

Function
REQ-009 A transfer SHALL occur on requester i when req_valid_i[i] and req_ready_o[i] are both high at a rising edge.
REQ-010 req_ready_o SHALL be combinational and SHALL grant at most one requester per cycle.
REQ-011 Requester i SHALL be eligible only when req_valid_i[i]=1, en_i=1 and outst[i] is less than MAX_OUTST.
REQ-012 Grant SHALL be round-robin: the first eligible requester at or after index ptr, wrapping modulo N_REQ.
REQ-013 On a transfer to requester i, ptr SHALL become (i+1) mod N_REQ, wrapping from N_REQ-1 to 0; ptr SHALL be unchanged when there is no transfer.
REQ-014 add_start_o, add_op_a_o and add_op_b_o SHALL be registered; for a transfer in cycle T, add_start_o=1 with the granted operands in cycle T+1, otherwise add_start_o=0.
REQ-015 add_op_a_o and add_op_b_o SHALL hold their previous values when no transfer occurs.
REQ-016 A tag delay line of LATENCY stages, each stage {valid, id}, SHALL be loaded together with add_start_o so that its output is aligned with add_done_i in cycle T+1+LATENCY.
REQ-017 When add_done_i=1 and the tag output is valid with id k, the block SHALL drive resp_valid_o[k]=1 and resp_res_o=add_res_i, registered, in cycle T+2+LATENCY (T+7 at default).
REQ-018 resp_res_o SHALL hold its value otherwise.
REQ-019 There SHALL be no response backpressure; requesters SHALL accept every resp_valid_o pulse.
REQ-020 outst[i] SHALL increment on a transfer of i and decrement on resp_valid_o[i]; when both occur in the same cycle, outst[i] SHALL be unchanged.
REQ-021 outst[i] SHALL never exceed MAX_OUTST or underflow.
REQ-022 Back-to-back grants SHALL sustain one operation per cycle.
REQ-023 Deasserting en_i SHALL stop new grants only; in-flight operations SHALL complete and respond normally.
REQ-024 busy_o SHALL be 1 while add_start_o, any tag stage, the response register or any outst counter is non-zero.
REQ-025 err_o SHALL be set when add_done_i=1 and the tag output is invalid, or when the tag output is valid and add_done_i=0.
REQ-026 err_o SHALL remain set until reset; a mismatched done SHALL produce no resp_valid_o.

Reset
REQ-027 Assertion of rst_n_i=0 SHALL asynchronously clear ptr, the tag line, all outst counters, add_start_o, add_op_a_o, add_op_b_o, resp_valid_o, resp_res_o and err_o to 0; busy_o SHALL then read 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations, with no responses after reset.
REQ-029 The adder's active-high reset SHALL be driven from the same reset source so that both blocks empty together.
REQ-030 The first grant SHALL be possible in the first cycle after rst_n_i deasserts.

Structure
REQ-031 The shared package SHALL hold the tag width, $clog2(N_REQ), and the outst counter width, $clog2(MAX_OUTST+1).
REQ-032 The round-robin grant logic SHALL be one sub-module, iob_fp_add_arb_rr, with inputs eligible and ptr and output a one-hot grant.
REQ-033 The adder SHALL stay external to this block.

Verification
REQ-034 Single request: requester 2 issues 0x3F800000+0x40000000 at T -> add_start_o at T+1; resp_valid_o=0b0100 and resp_res_o=0x40400000 at T+7.
REQ-035 All four requesters held valid for 8 cycles with ptr=0 -> grant order 0,1,2,3,0,1,2,3, one per cycle; responses return in the same order, 6 cycles after each add_start_o.
REQ-036 Requester 0 always valid, MAX_OUTST=4 -> exactly 4 grants; ready stays low until the first response, then one re-grant in the same cycle as the decrement.
REQ-037 en_i dropped with 3 operations in flight -> no new grants, 3 responses delivered, busy_o falls to 0 after the last response.
REQ-038 rst_n_i pulsed low with 5 in flight -> all outputs 0 immediately, no resp_valid_o afterwards, err_o stays 0.
REQ-039 Spurious add_done_i injected with the tag line empty -> err_o=1 and held; no resp_valid_o.
